// File: rtl/dtmr_supervisor.sv
// Dynamic TMR supervisor: selects simplex/voting, scrubs and retires faulty copies, raises a sticky fail-safe alarm.
// All outputs registered (one edge after the sampled inputs); `DTMR_FAULT_LOG_EN adds evt_cnt_o/last_victim_o.
module dtmr_supervisor #(
  parameter int FAULT_PERSIST = 4,
  parameter int SCRUB_CYC     = 8,
  parameter int SETTLE_CYC    = 8,
  parameter int QUIET_CYC     = 16,
  parameter int MAX_STRIKES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] s1_cmd,
  input  logic [3:0] s2_cmd,
  input  logic [3:0] s3_cmd,
  input  logic [3:0] d1_cmd,
  input  logic [3:0] d2_cmd,
  input  logic [3:0] d3_cmd,
  input  logic [2:0] fault,
  input  logic       hazard_i,
  output logic       state_o,
  output logic [2:0] copy_rst_o,
  output logic [2:0] copy_dis_o,
`ifdef DTMR_FAULT_LOG_EN
  output logic       alarm_o,
  output logic [7:0] evt_cnt_o,
  output logic [1:0] last_victim_o
`else
  output logic       alarm_o
`endif
);

  localparam int PW   = $clog2(FAULT_PERSIST + 1);
  localparam int QW   = $clog2(QUIET_CYC + 1);
  localparam int SW   = $clog2(MAX_STRIKES + 1);
  localparam int TMAX = (SCRUB_CYC > SETTLE_CYC) ? SCRUB_CYC : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] P_MAX     = PW'(FAULT_PERSIST);
  localparam logic [PW-1:0] P_ONE     = PW'(1);
  localparam logic [QW-1:0] Q_MAX     = QW'(QUIET_CYC);
  localparam logic [QW-1:0] Q_ONE     = QW'(1);
  localparam logic [SW-1:0] S_MAX     = SW'(MAX_STRIKES);
  localparam logic [SW-1:0] S_ONE     = SW'(1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] T_SCRUB   = TW'(SCRUB_CYC - 1);
  localparam logic [TW-1:0] T_SETTLE  = TW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_SIMPLEX,
    ST_VOTE,
    ST_SCRUB,
    ST_SETTLE,
    ST_FAILSAFE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pers_q [3];
  logic [PW-1:0]   pers_d [3];
  logic [PW-1:0]   pers_inc [3];
  logic [SW-1:0]   strike_q [3];
  logic [SW-1:0]   strike_d [3];
  logic [SW-1:0]   strike_new;
  logic [QW-1:0]   quiet_q, quiet_d, quiet_inc;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      victim_q, victim_d;
  logic [2:0]      copy_dis_q, copy_dis_d;
  logic            state_o_q, state_o_d;
  logic [2:0]      copy_rst_q, copy_rst_d;
  logic            alarm_q, alarm_d;

  logic [2:0]      fault_copy, fault_live, declared;
  logic [1:0]      decl_idx;
  logic            decl_multi, mismatch, retire_limit, scrub_entry;

  // Voter order is copy1 in the MSB; internally bit i is copy i+1.
  assign fault_copy = {fault[0], fault[1], fault[2]};
  assign fault_live = fault_copy & ~copy_dis_q;

  assign mismatch = (s1_cmd != s2_cmd) | (s1_cmd != s3_cmd) | (s2_cmd != s3_cmd) |
                    (d1_cmd != d2_cmd) | (d1_cmd != d3_cmd) | (d2_cmd != d3_cmd);

  assign retire_limit = (copy_dis_q[0] & copy_dis_q[1]) | (copy_dis_q[0] & copy_dis_q[2]) |
                        (copy_dis_q[1] & copy_dis_q[2]);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (!fault_live[i]) pers_inc[i] = '0;
      else if (pers_q[i] == P_MAX) pers_inc[i] = P_MAX;
      else pers_inc[i] = pers_q[i] + P_ONE;
      declared[i] = (pers_inc[i] == P_MAX);
    end
  end

  assign decl_multi = (declared[0] & declared[1]) | (declared[0] & declared[2]) |
                      (declared[1] & declared[2]);
  assign decl_idx   = declared[0] ? 2'd0 : (declared[1] ? 2'd1 : 2'd2);
  assign strike_new = (strike_q[decl_idx] == S_MAX) ? S_MAX : strike_q[decl_idx] + S_ONE;

  always_comb begin
    if ((|fault_live) || mismatch || hazard_i) quiet_inc = '0;
    else if (quiet_q == Q_MAX) quiet_inc = Q_MAX;
    else quiet_inc = quiet_q + Q_ONE;
  end

  always_comb begin
    state_d     = state_q;
    quiet_d     = '0;
    timer_d     = timer_q;
    victim_d    = victim_q;
    copy_dis_d  = copy_dis_q;
    scrub_entry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pers_d[i]   = '0;
      strike_d[i] = strike_q[i];
    end
    case (state_q)
      ST_SIMPLEX: begin
        if (mismatch || hazard_i) state_d = ST_VOTE;
      end
      ST_VOTE: begin
        for (int i = 0; i < 3; i++) pers_d[i] = pers_inc[i];
        quiet_d = quiet_inc;
        if (decl_multi) begin
          state_d = ST_FAILSAFE;
        end else if (|declared) begin
          state_d            = ST_SCRUB;
          scrub_entry        = 1'b1;
          victim_d           = decl_idx;
          timer_d            = '0;
          strike_d[decl_idx] = strike_new;
          if (strike_new == S_MAX) copy_dis_d[decl_idx] = 1'b1;
        end else if (quiet_inc == Q_MAX && copy_dis_q == 3'b000) begin
          state_d = ST_SIMPLEX;
        end
      end
      ST_SCRUB: begin
        if (timer_q == T_SCRUB) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      ST_SETTLE: begin
        if (timer_q == T_SETTLE) begin
          state_d = ST_VOTE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      ST_FAILSAFE: ;
      default: state_d = ST_FAILSAFE;
    endcase
    // Two retired copies leave no majority: this overrides whatever the state wanted.
    if (retire_limit && state_q != ST_FAILSAFE) state_d = ST_FAILSAFE;
  end

  always_comb begin
    state_o_d  = (state_d != ST_SIMPLEX);
    copy_rst_d = (state_d == ST_SCRUB) ? (3'b001 << victim_d) : 3'b000;
    alarm_d    = alarm_q | (state_d == ST_FAILSAFE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SIMPLEX;
      quiet_q    <= '0;
      timer_q    <= '0;
      victim_q   <= '0;
      copy_dis_q <= '0;
      state_o_q  <= 1'b0;
      copy_rst_q <= '0;
      alarm_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pers_q[i]   <= '0;
        strike_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      quiet_q    <= quiet_d;
      timer_q    <= timer_d;
      victim_q   <= victim_d;
      copy_dis_q <= copy_dis_d;
      state_o_q  <= state_o_d;
      copy_rst_q <= copy_rst_d;
      alarm_q    <= alarm_d;
      for (int i = 0; i < 3; i++) begin
        pers_q[i]   <= pers_d[i];
        strike_q[i] <= strike_d[i];
      end
    end
  end

  assign state_o    = state_o_q;
  assign copy_rst_o = copy_rst_q;
  assign copy_dis_o = copy_dis_q;
  assign alarm_o    = alarm_q;

`ifdef DTMR_FAULT_LOG_EN
  logic [7:0] evt_cnt_q, evt_cnt_d;
  logic [1:0] last_victim_q, last_victim_d;

  always_comb begin
    evt_cnt_d     = evt_cnt_q;
    last_victim_d = last_victim_q;
    if (scrub_entry && state_d == ST_SCRUB) begin
      if (evt_cnt_q != 8'hFF) evt_cnt_d = evt_cnt_q + 8'd1;
      last_victim_d = decl_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_q     <= '0;
      last_victim_q <= '0;
    end else begin
      evt_cnt_q     <= evt_cnt_d;
      last_victim_q <= last_victim_d;
    end
  end

  assign evt_cnt_o     = evt_cnt_q;
  assign last_victim_o = last_victim_q;
`else
  logic unused_log;
  assign unused_log = scrub_entry;
`endif

endmodule

// File: tb/tb_dtmr_supervisor.sv
// Directed bench for dtmr_supervisor: reset, simplex/vote switching, scrub timing, retirement, fail-safe.
module tb_dtmr_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s1_cmd, s2_cmd, s3_cmd, d1_cmd, d2_cmd, d3_cmd;
  logic [2:0] fault;
  logic       hazard_i;
  logic       state_o;
  logic [2:0] copy_rst_o, copy_dis_o;
  logic       alarm_o;
`ifdef DTMR_FAULT_LOG_EN
  logic [7:0] evt_cnt_o;
  logic [1:0] last_victim_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dtmr_supervisor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s1_cmd     (s1_cmd),
    .s2_cmd     (s2_cmd),
    .s3_cmd     (s3_cmd),
    .d1_cmd     (d1_cmd),
    .d2_cmd     (d2_cmd),
    .d3_cmd     (d3_cmd),
    .fault      (fault),
    .hazard_i   (hazard_i),
    .state_o    (state_o),
    .copy_rst_o (copy_rst_o),
    .copy_dis_o (copy_dis_o),
`ifdef DTMR_FAULT_LOG_EN
    .alarm_o       (alarm_o),
    .evt_cnt_o     (evt_cnt_o),
    .last_victim_o (last_victim_o)
`else
    .alarm_o    (alarm_o)
`endif
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_eq();
    s1_cmd = 4'h5; s2_cmd = 4'h5; s3_cmd = 4'h5;
    d1_cmd = 4'h3; d2_cmd = 4'h3; d3_cmd = 4'h3;
    fault = 3'b000; hazard_i = 1'b0;
  endtask

  task automatic declare(input logic [2:0] f);
    fault = f;
    step(4);
    fault = 3'b000;
  endtask

  initial begin
    rst_n    = 1'b1;
    s1_cmd   = 4'($urandom); s2_cmd = 4'($urandom); s3_cmd = 4'($urandom);
    d1_cmd   = 4'($urandom); d2_cmd = 4'($urandom); d3_cmd = 4'($urandom);
    fault    = 3'($urandom);
    hazard_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_copy_rst", 32'(copy_rst_o), 32'd0);
    check("rst_copy_dis", 32'(copy_dis_o), 32'd0);
    check("rst_alarm", 32'(alarm_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    set_eq();
    rst_n = 1'b1;
    step(3);
    check("simplex_idle", 32'(state_o), 32'd0);

    // Single-cycle mismatch enters voting; 16 quiet edges return to simplex.
    s2_cmd = 4'h6;
    step(1);
    check("mismatch_vote", 32'(state_o), 32'd1);
    s2_cmd = 4'h5;
    step(15);
    check("quiet15_vote", 32'(state_o), 32'd1);
    step(1);
    check("quiet16_simplex", 32'(state_o), 32'd0);

    // Copy2: a 3-cycle burst is not enough; 4 consecutive cycles declare it.
    hazard_i = 1'b1;
    step(1);
    hazard_i = 1'b0;
    check("hazard_vote", 32'(state_o), 32'd1);
    fault = 3'b010;
    step(3);
    fault = 3'b000;
    step(1);
    check("burst3_no_scrub", 32'(copy_rst_o), 32'd0);
    fault = 3'b010;
    step(3);
    check("persist3_no_scrub", 32'(copy_rst_o), 32'd0);
    step(1);
    check("copy2_scrub_start", 32'(copy_rst_o), 32'h2);
    step(7);
    check("copy2_scrub_last", 32'(copy_rst_o), 32'h2);
    step(1);
    check("copy2_scrub_end", 32'(copy_rst_o), 32'd0);
    check("settle_voting", 32'(state_o), 32'd1);
    step(7);
    check("settle_ignores_fault", 32'(copy_rst_o), 32'd0);
    // Last settle edge ignores fault, then 4 VOTE edges declare copy3 (voter bit0 -> copy_rst bit2).
    fault = 3'b001;
    step(4);
    check("settle_exit_pending", 32'(copy_rst_o), 32'd0);
    step(1);
    fault = 3'b000;
    check("copy3_strike1", 32'(copy_rst_o), 32'h4);
    check("copy3_not_dis1", 32'(copy_dis_o), 32'd0);

    step(16);
    declare(3'b001);
    check("copy3_strike2", 32'(copy_rst_o), 32'h4);
    check("copy3_not_dis2", 32'(copy_dis_o), 32'd0);
    step(16);
    declare(3'b001);
    check("copy3_strike3", 32'(copy_rst_o), 32'h4);
    check("copy3_retired", 32'(copy_dis_o), 32'h4);
`ifdef DTMR_FAULT_LOG_EN
    check("evt_cnt_4", 32'(evt_cnt_o), 32'd4);
    check("last_victim_3", 32'(last_victim_o), 32'd3);
`endif
    step(16);
    check("retired_back_vote", 32'(copy_rst_o), 32'd0);
    fault = 3'b001;
    step(6);
    check("retired_fault_ignored", 32'(copy_rst_o), 32'd0);
    fault = 3'b000;
    step(100);
    check("retired_no_simplex", 32'(state_o), 32'd1);
    check("retired_dis_sticky", 32'(copy_dis_o), 32'h4);
    check("retired_no_alarm", 32'(alarm_o), 32'd0);

    // Copies 1 and 2 declared on the same edge: fail-safe.
    fault = 3'b110;
    step(3);
    check("dual_pending_alarm", 32'(alarm_o), 32'd0);
    step(1);
    check("failsafe_alarm", 32'(alarm_o), 32'd1);
    check("failsafe_state", 32'(state_o), 32'd1);
    check("failsafe_copy_rst", 32'(copy_rst_o), 32'd0);
    for (int i = 0; i < 20; i++) begin
      fault    = 3'($urandom);
      hazard_i = 1'($urandom);
      s3_cmd   = 4'($urandom);
      step(1);
    end
    check("failsafe_alarm_hold", 32'(alarm_o), 32'd1);
    check("failsafe_state_hold", 32'(state_o), 32'd1);
    check("failsafe_rst_hold", 32'(copy_rst_o), 32'd0);

    // Fresh run: reset in the third scrub cycle of copy1.
    rst_n = 1'b0;
    #1;
    check("rst_clears_alarm", 32'(alarm_o), 32'd0);
    check("rst_clears_dis", 32'(copy_dis_o), 32'd0);
    step(2);
    set_eq();
    rst_n = 1'b1;
    hazard_i = 1'b1;
    step(1);
    hazard_i = 1'b0;
    declare(3'b100);
    check("copy1_scrub", 32'(copy_rst_o), 32'h1);
`ifdef DTMR_FAULT_LOG_EN
    check("evt_cnt_1", 32'(evt_cnt_o), 32'd1);
    check("last_victim_1", 32'(last_victim_o), 32'd1);
`endif
    hazard_i = 1'b1;
    step(2);
    hazard_i = 1'b0;
    check("copy1_scrub_cyc3", 32'(copy_rst_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midscrub_rst_copy_rst", 32'(copy_rst_o), 32'd0);
    check("midscrub_rst_state", 32'(state_o), 32'd0);
`ifdef DTMR_FAULT_LOG_EN
    check("midscrub_rst_evt", 32'(evt_cnt_o), 32'd0);
    check("midscrub_rst_victim", 32'(last_victim_o), 32'd0);
`endif
    step(2);
    rst_n = 1'b1;
    step(2);
    check("post_rst_simplex", 32'(state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
